clk_en_gen: RTL and testbench
=============================

# clk_en_gen

Parametrised, single-clock clock-enable generator that replaces fixed PLL output dividers for the slower core domains (e.g. CPU 6.25 MHz, pixel 25 MHz derived from one 50 MHz clock). It produces NUM_CH one-cycle enable strobes, each at refclk/D with a runtime-reprogrammable divisor. Divisor changes are glitch-free and take effect on a period boundary. A sync input re-aligns every channel, and a `locked` flag tells downstream logic when the enables are stable.

## Interface
- NUM_CH, 3: number of enable channels (1..16).
- DIV_W, 8: divisor width in bits; legal D = 0..2^DIV_W-1.
- DIV_INIT, {8'd8, 8'd2, 8'd1}: packed NUM_CH*DIV_W reset divisors. Channel i uses bits [i*DIV_W +: DIV_W].
- LOCK_CYCLES, 16: cycles from reset/sync release until `locked` asserts (≥1).
- Clocking and reset: one clock; reset is synchronous and active-high.
- refclk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sync  in  1  one-cycle pulse that re-aligns all channels and restarts lock.
- cfg_valid  in  1  divisor update request.
- cfg_ready  out  1  update slot free.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_div  in  DIV_W  new divisor.
- en_out  out  NUM_CH  per-channel enable strobes; registered.
- locked  out  1  enables stable.

## Operation
- Per channel: divisor register div[i] and counter cnt[i] (DIV_W bits). cnt counts 0..div-1 and wraps to 0.
- en_out[i] is registered high for the cycle following the edge at which cnt[i]==div[i]-1 was sampled. This gives exactly one high cycle per div[i] cycles.
- div=1: en_out held high continuously. div=0: channel disabled, cnt held 0, en_out held 0.
- Config handshake: a transfer occurs on an edge with cfg_valid && cfg_ready. The request is latched into a single pending slot, and cfg_ready drops on the next cycle.
  - The pending update is applied at the target channel's next wrap edge (the same edge that launches its strobe). From then on the channel counts with the new D.
  - It is applied on the next edge instead if the target is disabled (div=0).
  - cfg_ready re-asserts the cycle after application.
  - cfg_ch ≥ NUM_CH: the request is accepted and discarded; cfg_ready stays high.
- sync (registered edge), applied to all channels at once:
  - all cnt cleared to 0 and en_out cleared;
  - any pending update is applied immediately;
  - locked cleared and the lock counter restarted.
  - Afterwards channels behave exactly as after reset.
  - cfg transfer on the same edge as sync: it is accepted and applied at that edge.
- locked: a lock counter of $clog2(LOCK_CYCLES+1) bits counts from 0 after reset/sync release. locked rises when the count reaches LOCK_CYCLES and then stays high. Config updates never drop locked.

## Timing
- Reset values: en_out=0, locked=0, cfg_ready=1, cnt=0, div=DIV_INIT, pending slot empty.
- Edge 1 is the first rising edge with rst low.
  - Channel with D≥1: first en_out pulse is high in the cycle after edge D, then repeats every D cycles.
  - locked is high in the cycle after edge LOCK_CYCLES.
- Strobe latency from the counter compare is 1 cycle, and identical across channels. Channels with equal D are phase-aligned after reset or sync.
- Reset mid-operation wins over everything: a pending update is dropped and DIV_INIT is restored.
- No combinational path from inputs to outputs.

## Structure
- Package clk_en_pkg holds:
  - ch_idx_w(NUM_CH) function (clog2, min 1);
  - the default DIV_INIT for the 50 MHz core (8,2,1);
  - the lock-counter width function.
- Sub-module clk_en_channel: one cnt/div/en pipe with inputs load_div, new_div, sync, and outputs wrap, en. It is instantiated NUM_CH times via generate.
- The top level owns the pending slot, the handshake and the lock counter.

## Test plan
- Defaults D={1,2,8}, rst released then 80 cycles -> en_out pulse counts 80/40/10; first pulses in cycles 1/2/8. locked high from cycle 16.
- cfg ch2←4 at cycle 3 (mid-period) -> current 8-cycle period completes (pulse at cycle 8), next pulses at 12 and 16. cfg_ready is low from cycle 4 until the cycle after the apply edge.
- cfg ch1←0, then later ch1←3 -> en_out[1] stays 0 while disabled; after the second cfg its pulses come every 3 cycles, applied one edge after acceptance.
- sync pulse at cycle 37 with D={3,5} -> both channels restart from 0; next pulses 3 and 5 cycles after the sync edge. locked low for 16 cycles, then high.
- cfg_ch=3 with NUM_CH=3 -> accepted, cfg_ready stays 1, no divisor changes.
- rst asserted while an update is pending -> all outputs return to reset values, div=DIV_INIT, pending update lost.

Source files
------------

// File: rtl/clk_en_gen_pkg.sv
// clk_en_pkg: shared constants and sizing helpers for the clock-enable generator.
//   ch_idx_w(n)    - width of a channel index (clog2, never below 1)
//   lock_cnt_w(l)  - width of a counter that must be able to hold the value l
//   DIV_INIT_50M   - reset divisors for the 50 MHz core: ch0=1, ch1=2, ch2=8
package clk_en_pkg;

    localparam int NUM_CH_50M = 3;
    localparam int DIV_W_50M  = 8;
    localparam logic [NUM_CH_50M*DIV_W_50M-1:0] DIV_INIT_50M = {8'd8, 8'd2, 8'd1};

    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int lock_cnt_w(input int l);
        return (l <= 1) ? 1 : $clog2(l + 1);
    endfunction

endpackage

// File: rtl/clk_en_gen_if.sv
// clk_en_gen_if: divisor-update handshake.
//   cfg_valid - update request (master -> slave)
//   cfg_ready - pending slot free (slave -> master)
//   cfg_ch    - target channel index
//   cfg_div   - new divisor (0 disables the channel)
interface clk_en_gen_if
    import clk_en_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 8
);
    localparam int CH_W = ch_idx_w(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_en_gen_channel.sv
// clk_en_channel: one divisor/counter/strobe pipe.
//   refclk, rst  - clock and synchronous active-high reset
//   sync         - restart the period from zero and clear the strobe
//   load_div     - take new_div as divisor on this edge (counter restarts at 0)
//   new_div      - divisor to load
//   wrap         - this edge is a legal load point (period end, or channel disabled)
//   en           - registered one-cycle enable strobe
module clk_en_channel #(
    parameter int               DIV_W   = 8,
    parameter logic [DIV_W-1:0] DIV_RST = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             sync,
    input  logic             load_div,
    input  logic [DIV_W-1:0] new_div,
    output logic             wrap,
    output logic             en
);
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             disabled;
    logic             at_end;

    assign disabled = (div_q == '0);
    assign at_end   = !disabled && (cnt_q == div_q - DIV_W'(1));
    // A disabled channel has no period to finish, so it accepts a load at once.
    assign wrap     = at_end || disabled;
    assign en       = en_q;

    always_comb begin
        div_d = div_q;
        en_d  = at_end;
        if (disabled || at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        // Loads only ever happen at a wrap or a sync, where the counter restarts anyway.
        if (load_div) begin
            div_d = new_div;
            cnt_d = '0;
        end
        if (sync) begin
            cnt_d = '0;
            en_d  = 1'b0;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            div_q <= DIV_RST;
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            en_q  <= en_d;
        end
    end
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: NUM_CH clock-enable strobes, each at refclk/D, with a single-slot
// glitch-free divisor update path, a global re-align (sync) and a lock flag.
//   refclk  - sole clock
//   rst     - synchronous active-high reset (restores DIV_INIT, drops pending update)
//   sync    - re-aligns all channels, applies any pending update, restarts lock
//   cfg     - divisor update handshake (slave side)
//   en_out  - registered per-channel enable strobes
//   locked  - high once LOCK_CYCLES edges have passed since reset/sync
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int                      NUM_CH      = 3,
    parameter int                      DIV_W       = 8,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT    = DIV_INIT_50M,
    parameter int                      LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              sync,
    clk_en_gen_if.slave       cfg,
    output logic [NUM_CH-1:0] en_out,
    output logic              locked
);
    localparam int CH_W = ch_idx_w(NUM_CH);
    localparam int LCW  = lock_cnt_w(LOCK_CYCLES);

    logic             pend_q, pend_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;

    logic [NUM_CH-1:0] wrap_w;
    logic [NUM_CH-1:0] en_w;
    logic [NUM_CH-1:0] load_w;
    logic [DIV_W-1:0]  new_div;
    logic              xfer;
    logic              ch_ok;

    assign xfer  = cfg.cfg_valid && cfg_ready_q;
    assign ch_ok = (32'(cfg.cfg_ch) < 32'(NUM_CH));
    // A transfer can only happen with the slot empty, so the slot and a fresh
    // request never compete for the load bus.
    assign new_div = pend_q ? pend_div_q : cfg.cfg_div;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Pending update lands at the target's wrap; sync forces it (or a
            // same-edge request) in immediately.
            assign load_w[gi] =
                (pend_q && (pend_ch_q == CH_W'(gi)) && (wrap_w[gi] || sync)) ||
                (sync && xfer && ch_ok && (cfg.cfg_ch == CH_W'(gi)));

            clk_en_channel #(
                .DIV_W   (DIV_W),
                .DIV_RST (DIV_INIT[gi*DIV_W +: DIV_W])
            ) u_ch (
                .refclk   (refclk),
                .rst      (rst),
                .sync     (sync),
                .load_div (load_w[gi]),
                .new_div  (new_div),
                .wrap     (wrap_w[gi]),
                .en       (en_w[gi])
            );
        end
    endgenerate

    always_comb begin
        pend_d     = pend_q;
        pend_ch_d  = pend_ch_q;
        pend_div_d = pend_div_q;
        if (sync || (pend_q && (|load_w))) begin
            pend_d = 1'b0;
        end else if (xfer && ch_ok) begin
            pend_d     = 1'b1;
            pend_ch_d  = cfg.cfg_ch;
            pend_div_d = cfg.cfg_div;
        end
        cfg_ready_d = !pend_d;

        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (sync) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            if (lock_cnt_q != LCW'(LOCK_CYCLES)) begin
                lock_cnt_d = lock_cnt_q + LCW'(1);
            end
            if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
                locked_d = 1'b1;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_ch_q   <= '0;
            pend_div_q  <= '0;
            cfg_ready_q <= 1'b1;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_ch_q   <= pend_ch_d;
            pend_div_q  <= pend_div_d;
            cfg_ready_q <= cfg_ready_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign en_out        = en_w;
    assign locked        = locked_q;
endmodule

// File: tb/tb_clk_en_gen.sv
// Testbench for clk_en_gen: drives directed and random cfg/sync/rst stimulus,
// predicts every output cycle with a next-pulse-schedule model and checks the
// DUT through a queue-based scoreboard.
module tb_clk_en_gen;
    localparam int NUM_CH = 3;
    localparam int DIV_W  = 8;
    localparam int LOCK   = 16;

    typedef struct {
        int                  edge_n;
        logic [NUM_CH+1:0]   v;      // {cfg_ready, locked, en_out}
    } exp_t;

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    logic sync   = 1'b0;
    logic [NUM_CH-1:0] en_out;
    logic locked;

    clk_en_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_if ();

    clk_en_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DIV_INIT    ({8'd8, 8'd2, 8'd1}),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .sync   (sync),
        .cfg    (cfg_if.slave),
        .en_out (en_out),
        .locked (locked)
    );

    always #5 refclk = ~refclk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: each channel keeps its divisor and the absolute edge
    // number of its next strobe; the lock flag is a deadline edge.
    int m_init[NUM_CH] = '{1, 2, 8};
    int m_div[NUM_CH];
    int m_next[NUM_CH];
    int m_edge    = 0;
    int m_lock_at = 0;
    bit m_pend    = 0;
    int m_pch     = 0;
    int m_pdiv    = 0;
    bit m_ready   = 1;

    function automatic void m_restart();
        for (int i = 0; i < NUM_CH; i++) m_next[i] = m_edge + m_div[i];
        m_lock_at = m_edge + LOCK;
    endfunction

    function automatic logic [NUM_CH+1:0] m_step(bit r, bit s, bit v, int ch, int dv);
        logic [NUM_CH-1:0] en;
        bit lk;
        bit xfer;
        en   = '0;
        m_edge++;
        xfer = v && m_ready;
        if (r) begin
            for (int i = 0; i < NUM_CH; i++) m_div[i] = m_init[i];
            m_pend = 0;
            m_restart();
            lk = 0;
        end else if (s) begin
            if (m_pend) m_div[m_pch] = m_pdiv;
            if (xfer && ch < NUM_CH) m_div[ch] = dv;
            m_pend = 0;
            m_restart();
            lk = 0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_div[i] > 0 && m_edge == m_next[i]) begin
                    en[i] = 1'b1;
                    m_next[i] = m_edge + m_div[i];
                end
            end
            if (m_pend && (m_div[m_pch] == 0 || en[m_pch])) begin
                m_div[m_pch]  = m_pdiv;
                m_next[m_pch] = m_edge + m_pdiv;
                m_pend = 0;
            end
            if (xfer && ch < NUM_CH) begin
                m_pend = 1;
                m_pch  = ch;
                m_pdiv = dv;
            end
            lk = (m_edge >= m_lock_at);
        end
        m_ready = !m_pend;
        return {m_ready, lk, en};
    endfunction

    task automatic step(bit r, bit s, bit v, int ch, int dv);
        exp_t e;
        bit   will_xfer;
        @(negedge refclk);
        rst              = r;
        sync             = s;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_ch    = 2'(ch);
        cfg_if.cfg_div   = 8'(dv);
        will_xfer = v && m_ready;
        e.v      = m_step(r, s, v, ch, dv);
        e.edge_n = m_edge;
        exp_q.push_back(e);
        if (r) $display("edge %0d: rst", m_edge);
        else if (s) $display("edge %0d: sync%s", m_edge, will_xfer ? " with cfg" : "");
        if (!r && will_xfer) $display("edge %0d: cfg ch=%0d div=%0d", m_edge, ch, dv);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic cfg_when_ready(int ch, int dv);
        int waited = 0;
        while (!m_ready && waited < 300) begin
            idle(1);
            waited++;
        end
        n_checks++;
        if (!m_ready) begin
            n_errors++;
            $display("FAIL cfg_wait: slot still busy after %0d cycles, required free", waited);
        end
        step(0, 0, 1, ch, dv);
    endtask

    // Monitor: every cycle's outputs are one transaction, compared against the
    // oldest prediction.
    initial begin
        exp_t e;
        logic [NUM_CH+1:0] got;
        forever begin
            @(posedge refclk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {cfg_if.cfg_ready, locked, en_out};
                n_checks++;
                if (got !== e.v) begin
                    n_errors++;
                    $display("FAIL outputs edge=%0d {ready,locked,en}: got=%b exp=%b",
                             e.edge_n, got, e.v);
                end
            end
        end
    end

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;

        // Defaults over 80 cycles after release.
        repeat (3) step(1, 0, 0, 0, 0);
        idle(80);

        // Mid-period update of ch2 (8 -> 4), request sampled at edge 4.
        step(1, 0, 0, 0, 0);
        idle(3);
        step(0, 0, 1, 2, 4);
        idle(20);

        // Disable ch1, then re-enable at 3.
        cfg_when_ready(1, 0);
        idle(8);
        cfg_when_ready(1, 3);
        idle(12);

        // Out-of-range channel is swallowed.
        cfg_when_ready(3, 77);
        idle(4);

        // D={3,5} on ch0/ch1, then a sync re-aligns.
        cfg_when_ready(0, 3);
        cfg_when_ready(1, 5);
        idle(10);
        step(0, 1, 0, 0, 0);
        idle(25);

        // Reset while an update is pending.
        cfg_when_ready(2, 9);
        step(1, 0, 0, 0, 0);
        idle(20);

        // cfg on the same edge as sync.
        cfg_when_ready(0, 0);
        idle(3);
        while (!m_ready) idle(1);
        step(0, 1, 1, 0, 6);
        idle(20);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            bit r, s, v;
            int ch, dv;
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 3) == 0);
            ch = $urandom_range(0, 3);
            dv = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 9);
            step(r, s, v, ch, dv);
        end
        idle(5);

        repeat (3) @(posedge refclk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d predictions unchecked, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
